// File: rtl/digdug_spatr_pkg.sv
// Shared constants, FSM state type and sprite attribute field layout for the
// DigDug sprite attribute table front-end.
package digdug_spatr_pkg;

   localparam int ENTRIES = 128;
   localparam int LANES   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COPY  = 2'd1,
      DRAIN = 2'd2
   } spatr_state_e;

   localparam logic [1:0] LANE0     = 2'd0;
   localparam logic [1:0] LANE1     = 2'd1;
   localparam logic [1:0] LANE2     = 2'd2;
   localparam logic [1:0] LANE_NONE = 2'd3;

   localparam int ATR0_CODE_LSB  = 0;
   localparam int ATR0_Y_LSB     = 8;
   localparam int ATR0_FLIPX_BIT = 16;
   localparam int ATR0_FLIPY_BIT = 17;
   localparam int ATR1_COLOR_LSB = 0;
   localparam int ATR1_X_LSB     = 8;
   localparam int ATR1_DIS_BIT   = 17;

   function automatic logic [23:0] atr0_pack(input logic [7:0] code, input logic [7:0] y,
                                             input logic flipx, input logic flipy);
      logic [23:0] v;
      v = 24'd0;
      v[ATR0_CODE_LSB +: 8] = code;
      v[ATR0_Y_LSB +: 8]    = y;
      v[ATR0_FLIPX_BIT]     = flipx;
      v[ATR0_FLIPY_BIT]     = flipy;
      return v;
   endfunction

   function automatic logic [23:0] atr1_pack(input logic [5:0] color, input logic [7:0] x,
                                             input logic dis);
      logic [23:0] v;
      v = 24'd0;
      v[ATR1_COLOR_LSB +: 6] = color;
      v[ATR1_X_LSB +: 8]     = x;
      v[ATR1_DIS_BIT]        = dis;
      return v;
   endfunction

endpackage

// File: rtl/digdug_spatr_lane.sv
// Simple dual-port RAM (one write port, one registered read port) with
// write-first behaviour when both ports address the same word.
module digdug_spatr_lane #(
   parameter int AW = 7,
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];
   logic [DW-1:0] r_rdata;

   // storage array; contents survive reset
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // registered read with same-address bypass of the incoming write
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= {DW{1'b0}};
      end else if (i_we && (i_waddr == i_raddr)) begin
         r_rdata <= i_wdata;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/digdug_spatr_ram.sv
// Sprite attribute table: CPU-written shadow table copied into a ping-pong
// display buffer on every vertical-blank rise, then the banks are swapped.
module digdug_spatr_ram
   import digdug_spatr_pkg::*;
#(
   parameter int AW = 7,
   parameter int DW = 24
) (
   input  logic          RCLK,
   input  logic          RESET_N,
   input  logic          VBLK,
   input  logic [AW+1:0] CPUAD,
   input  logic          CPUWE,
   input  logic [7:0]    CPUDI,
   output logic [7:0]    CPUDO,
   input  logic [AW-1:0] SPATAD,
   output logic [DW-1:0] SPATDT,
   output logic          BUSY,
   output logic          SWAP,
   output logic          BANK
);

   spatr_state_e  r_state;
   spatr_state_e  w_state_next;
   logic [AW-1:0] r_cnt;
   logic [AW-1:0] w_cnt_next;
   logic          w_cp_we_next;
   logic          w_flip;
   logic          r_cp_we;
   logic [AW-1:0] r_cp_addr;
   logic          r_vblk_prev;
   logic          r_busy;
   logic          r_swap;
   logic          r_bank;
   logic [1:0]    r_cpu_lane;
   logic          w_vblk_rise;
   logic [1:0]    w_cpu_lane;
   logic [AW-1:0] w_cpu_entry;
   logic [7:0]    w_cpu_rd [LANES];
   logic [DW-1:0] w_cp_rd;
   logic [7:0]    w_cpudo;

   assign w_cpu_lane  = CPUAD[AW+1:AW];
   assign w_cpu_entry = CPUAD[AW-1:0];
   assign w_vblk_rise = VBLK & ~r_vblk_prev;

   // Each lane is mirrored so CPU readback and the copy engine own separate read ports.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic w_we;
      assign w_we = CPUWE & (w_cpu_lane == 2'(l));

      digdug_spatr_lane #(.AW(AW), .DW(8)) u_cpu_port (
         .i_clk   (RCLK),
         .i_rst_n (RESET_N),
         .i_we    (w_we),
         .i_waddr (w_cpu_entry),
         .i_wdata (CPUDI),
         .i_raddr (w_cpu_entry),
         .o_rdata (w_cpu_rd[l])
      );

      digdug_spatr_lane #(.AW(AW), .DW(8)) u_copy_port (
         .i_clk   (RCLK),
         .i_rst_n (RESET_N),
         .i_we    (w_we),
         .i_waddr (w_cpu_entry),
         .i_wdata (CPUDI),
         .i_raddr (r_cnt),
         .o_rdata (w_cp_rd[8*l +: 8])
      );
   end

   digdug_spatr_lane #(.AW(AW+1), .DW(DW)) u_display (
      .i_clk   (RCLK),
      .i_rst_n (RESET_N),
      .i_we    (r_cp_we),
      .i_waddr ({~r_bank, r_cp_addr}),
      .i_wdata (w_cp_rd),
      .i_raddr ({r_bank, SPATAD}),
      .o_rdata (SPATDT)
   );

   // FSM state register
   always_ff @(posedge RCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_vblk_rise) begin
               w_state_next = COPY;
            end else begin
               w_state_next = IDLE;
            end
         end
         COPY: begin
            if (r_cnt == {AW{1'b1}}) begin
               w_state_next = DRAIN;
            end else begin
               w_state_next = COPY;
            end
         end
         DRAIN:   w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // FSM outputs: counter advance, copy write strobe and bank flip
   always_comb begin
      w_cnt_next   = {AW{1'b0}};
      w_cp_we_next = 1'b0;
      w_flip       = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_next = {AW{1'b0}};
         end
         COPY: begin
            w_cnt_next   = r_cnt + {{(AW-1){1'b0}}, 1'b1};
            w_cp_we_next = 1'b1;
         end
         DRAIN: begin
            w_flip = 1'b1;
         end
         default: begin
            w_cnt_next = {AW{1'b0}};
         end
      endcase
   end

   // copy pipeline, bank control and status registers
   always_ff @(posedge RCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cnt       <= {AW{1'b0}};
         r_cp_we     <= 1'b0;
         r_cp_addr   <= {AW{1'b0}};
         r_vblk_prev <= 1'b0;
         r_busy      <= 1'b0;
         r_swap      <= 1'b0;
         r_bank      <= 1'b0;
         r_cpu_lane  <= 2'd0;
      end else begin
         r_cnt       <= w_cnt_next;
         r_cp_we     <= w_cp_we_next;
         r_cp_addr   <= r_cnt;
         r_vblk_prev <= VBLK;
         r_busy      <= (w_state_next != IDLE);
         r_swap      <= w_flip;
         r_bank      <= r_bank ^ w_flip;
         r_cpu_lane  <= w_cpu_lane;
      end
   end

   // CPU readback lane select; the unmapped lane reads as all ones
   always_comb begin
      w_cpudo = 8'hFF;
      case (r_cpu_lane)
         LANE0:     w_cpudo = w_cpu_rd[0];
         LANE1:     w_cpudo = w_cpu_rd[1];
         LANE2:     w_cpudo = w_cpu_rd[2];
         LANE_NONE: w_cpudo = 8'hFF;
         default:   w_cpudo = 8'hFF;
      endcase
   end

   assign CPUDO = w_cpudo;
   assign BUSY  = r_busy;
   assign SWAP  = r_swap;
   assign BANK  = r_bank;

endmodule
